// File: rtl/rename_dispatch_pkg.sv
// Shared rename/issue constants and the issueinfo field layout.
// The issue queue slices issueinfo with these same offsets.
package rename_dispatch_pkg;
  localparam int NUM_ARCH = 32;
  localparam int NUM_PHYS = 64;
  localparam int PHYS_W   = 6;
  localparam int ARCH_W   = 5;
  localparam int CTRL_W   = 151;
  localparam int INFO_W   = 186;

  localparam int MAPA_LSB  = 0;
  localparam int MAPB_LSB  = 6;
  localparam int MAPWR_LSB = 12;
  localparam int CTRL_LSB  = 18;

  localparam int C_REGWR  = 93;
  localparam int C_MEMWR  = 94;
  localparam int C_REGDST = 99;
  localparam int C_LINK   = 100;

  typedef logic [PHYS_W-1:0]   ptag_t;
  typedef logic [ARCH_W-1:0]   areg_t;
  typedef logic [NUM_PHYS-1:0] pmask_t;
  typedef logic [CTRL_W-1:0]   ctrl_t;
  typedef logic [INFO_W-1:0]   info_t;

  function automatic info_t pack_info(
    ptag_t a, ptag_t b, ptag_t w, ctrl_t c
  );
    info_t r;
    r = '0;
    r[MAPA_LSB+:PHYS_W]  = a;
    r[MAPB_LSB+:PHYS_W]  = b;
    r[MAPWR_LSB+:PHYS_W] = w;
    r[CTRL_LSB+:CTRL_W]  = c;
    return r;
  endfunction
endpackage

// File: rtl/rename_dispatch_if.sv
// Rename -> issue queue bundle.
// master = rename stage, slave = issue queue.
interface rename_dispatch_if;
  import rename_dispatch_pkg::*;
  logic        rename_enque;
  logic [31:0] rename_instr_num;
  info_t       rename_issueinfo;
  pmask_t      busy;
  logic        issue_halt;

  modport master (
    output rename_enque, rename_instr_num,
    output rename_issueinfo, busy,
    input  issue_halt
  );
  modport slave (
    input  rename_enque, rename_instr_num,
    input  rename_issueinfo, busy,
    output issue_halt
  );
endinterface

// File: rtl/rename_freelist.sv
// Free physical register bitmap.
// Allocates the lowest free tag; flush reloads from an RRAT mask.
module rename_freelist
  import rename_dispatch_pkg::*;
(
  input  logic   clk,
  input  logic   rst_n,
  input  logic   alloc,
  input  logic   rel,
  input  ptag_t  rel_tag,
  input  logic   flush,
  input  pmask_t flush_mask,
  output ptag_t  alloc_tag,
  output logic   empty
);
  pmask_t free;

  always_comb begin
    alloc_tag = '0;
    for (int p = NUM_PHYS-1; p > 0; p--)
      if (free[p]) alloc_tag = ptag_t'(p);
  end

  assign empty = ~|free;

  // Tag 0 is never placed on the list.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      free <= {{(NUM_PHYS-NUM_ARCH){1'b1}},
               {NUM_ARCH{1'b0}}};
    end else if (flush) begin
      free <= flush_mask & ~pmask_t'(1);
    end else begin
      if (alloc)
        free[alloc_tag] <= 1'b0;
      if (rel && rel_tag != '0)
        free[rel_tag] <= 1'b1;
    end
  end
endmodule

// File: rtl/rename_dispatch.sv
// Register rename and dispatch stage.
// Speculative RAT, retirement RAT, free list and ready table.
module rename_dispatch
  import rename_dispatch_pkg::*;
(
  input  logic   CLK,
  input  logic   RESET,
  input  logic   STALL,
  input  logic   FLUSH,
  input  logic   dec_valid,
  input  areg_t  dec_rs,
  input  areg_t  dec_rt,
  input  areg_t  dec_rd,
  input  ctrl_t  dec_ctrl,
  output logic   rename_stall,
  rename_dispatch_if.master iq,
  output areg_t  rename_arch_dst,
  output ptag_t  rename_old_map,
  input  logic   exe_broadcast,
  input  ptag_t  exe_broadcast_map,
  input  logic   rob_commit,
  input  areg_t  rob_commit_arch,
  input  ptag_t  rob_commit_new,
  input  ptag_t  rob_commit_old
);
  ptag_t  rat     [NUM_ARCH];
  ptag_t  rrat    [NUM_ARCH];
  ptag_t  rrat_nx [NUM_ARCH];
  areg_t  arch_dst;
  ptag_t  new_tag, map_wr;
  pmask_t in_use;
  logic   need_alloc, accept, free_empty, do_alloc;
  logic [31:0] seq;

  always_comb begin
    arch_dst = dec_rt;
    if (dec_ctrl[C_REGDST])
      arch_dst = dec_rd;
    else if (dec_ctrl[C_LINK])
      arch_dst = areg_t'(NUM_ARCH-1);
  end

  assign need_alloc = dec_ctrl[C_REGWR]
                   && arch_dst != '0;
  assign accept = dec_valid && !STALL && !FLUSH
               && !iq.issue_halt
               && !(need_alloc && free_empty);
  assign rename_stall = dec_valid && !accept;
  assign do_alloc = accept && need_alloc;

  always_comb begin
    map_wr = '0;
    if (need_alloc)
      map_wr = new_tag;
    else if (dec_ctrl[C_MEMWR])
      map_wr = rat[dec_rt];
  end

  always_comb begin
    rrat_nx = rrat;
    if (rob_commit && rob_commit_arch != '0)
      rrat_nx[rob_commit_arch] = rob_commit_new;
  end

  always_comb begin
    in_use = '0;
    for (int i = 0; i < NUM_ARCH; i++)
      in_use[rrat_nx[i]] = 1'b1;
  end

  rename_freelist u_free (
    .clk        (CLK),
    .rst_n      (RESET),
    .alloc      (do_alloc),
    .rel        (rob_commit),
    .rel_tag    (rob_commit_old),
    .flush      (FLUSH),
    .flush_mask (~in_use),
    .alloc_tag  (new_tag),
    .empty      (free_empty)
  );

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      for (int i = 0; i < NUM_ARCH; i++) begin
        rat[i]  <= ptag_t'(i);
        rrat[i] <= ptag_t'(i);
      end
    end else begin
      rrat <= rrat_nx;
      if (FLUSH)
        rat <= rrat_nx;
      else if (do_alloc)
        rat[arch_dst] <= new_tag;
    end
  end

  // Allocation is applied after broadcast so it wins a same-tag clash.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      iq.busy <= '1;
    end else if (FLUSH) begin
      iq.busy <= '1;
    end else begin
      if (exe_broadcast && exe_broadcast_map != '0)
        iq.busy[exe_broadcast_map] <= 1'b1;
      if (do_alloc)
        iq.busy[new_tag] <= 1'b0;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      iq.rename_enque     <= 1'b0;
      iq.rename_instr_num <= '0;
      iq.rename_issueinfo <= '0;
      rename_arch_dst     <= '0;
      rename_old_map      <= '0;
      seq                 <= 32'd1;
    end else if (FLUSH) begin
      iq.rename_enque     <= 1'b0;
      iq.rename_issueinfo <= '0;
      rename_arch_dst     <= '0;
      rename_old_map      <= '0;
    end else if (!STALL) begin
      iq.rename_enque <= accept;
      if (accept) begin
        iq.rename_instr_num <= seq;
        iq.rename_issueinfo <= pack_info(
          rat[dec_rs], rat[dec_rt], map_wr, dec_ctrl);
        rename_arch_dst <= need_alloc ? arch_dst : '0;
        rename_old_map  <= need_alloc ? rat[arch_dst] : '0;
        seq <= (seq == '1) ? 32'd1 : seq + 32'd1;
      end
    end
  end
endmodule

// File: tb/tb_rename_dispatch.sv
// Scoreboard bench for rename_dispatch against a
// table-level reference model of rename, free list and ROB.
module tb_rename_dispatch;
  import rename_dispatch_pkg::*;

  logic  CLK = 1'b0;
  logic  RESET = 1'b0;
  logic  STALL, FLUSH, dec_valid;
  areg_t dec_rs, dec_rt, dec_rd;
  ctrl_t dec_ctrl;
  logic  rename_stall;
  areg_t rename_arch_dst;
  ptag_t rename_old_map;
  logic  exe_broadcast;
  ptag_t exe_broadcast_map;
  logic  rob_commit;
  areg_t rob_commit_arch;
  ptag_t rob_commit_new, rob_commit_old;

  rename_dispatch_if ifc ();

  rename_dispatch dut (
    .CLK               (CLK),
    .RESET             (RESET),
    .STALL             (STALL),
    .FLUSH             (FLUSH),
    .dec_valid         (dec_valid),
    .dec_rs            (dec_rs),
    .dec_rt            (dec_rt),
    .dec_rd            (dec_rd),
    .dec_ctrl          (dec_ctrl),
    .rename_stall      (rename_stall),
    .iq                (ifc),
    .rename_arch_dst   (rename_arch_dst),
    .rename_old_map    (rename_old_map),
    .exe_broadcast     (exe_broadcast),
    .exe_broadcast_map (exe_broadcast_map),
    .rob_commit        (rob_commit),
    .rob_commit_arch   (rob_commit_arch),
    .rob_commit_new    (rob_commit_new),
    .rob_commit_old    (rob_commit_old)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] num;
    info_t       info;
    areg_t       dst;
    ptag_t       old;
  } exp_t;

  typedef struct {
    areg_t arch;
    ptag_t nw;
    ptag_t old;
  } rob_t;

  exp_t  sb [$];
  rob_t  rob [$];
  ptag_t m_rat  [32];
  ptag_t m_rrat [32];
  bit    m_free [64];
  bit    m_busy [64];
  logic [31:0] m_cnt;
  logic  last_stall;
  int    checks = 0;
  int    errors = 0;

  function automatic void chk(string n,
      logic [255:0] act, logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", n, act, exp);
    end
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < 32; i++) begin
      m_rat[i]  = ptag_t'(i);
      m_rrat[i] = ptag_t'(i);
    end
    for (int p = 0; p < 64; p++) begin
      m_free[p] = (p >= 32);
      m_busy[p] = 1'b1;
    end
    m_cnt = 32'd1;
    rob.delete();
    sb.delete();
  endfunction

  function automatic ctrl_t rand_ctrl();
    logic [159:0] r;
    r = {$urandom, $urandom, $urandom,
         $urandom, $urandom};
    return r[CTRL_W-1:0];
  endfunction

  task automatic idle();
    dec_valid = 0; dec_rs = 0; dec_rt = 0; dec_rd = 0;
    dec_ctrl = '0; STALL = 0; FLUSH = 0;
    ifc.issue_halt = 0; exe_broadcast = 0;
    exe_broadcast_map = 0; rob_commit = 0;
    rob_commit_arch = 0; rob_commit_new = 0;
    rob_commit_old = 0;
  endtask

  task automatic set_instr(int rs, int rt, int rd,
      bit rdst, bit rwr, bit mwr, bit lnk);
    dec_valid = 1;
    dec_rs = areg_t'(rs);
    dec_rt = areg_t'(rt);
    dec_rd = areg_t'(rd);
    dec_ctrl = rand_ctrl();
    dec_ctrl[C_REGDST] = rdst;
    dec_ctrl[C_REGWR]  = rwr;
    dec_ctrl[C_MEMWR]  = mwr;
    dec_ctrl[C_LINK]   = lnk;
  endtask

  task automatic commit_front();
    rob_t r;
    if (rob.size() > 0) begin
      r = rob.pop_front();
      rob_commit = 1;
      rob_commit_arch = r.arch;
      rob_commit_new = r.nw;
      rob_commit_old = r.old;
    end
  endtask

  // Inputs are already set; check, predict, then cross the edge.
  task automatic step();
    logic [63:0] bm;
    int    nt;
    areg_t dst;
    bit    need, acc;
    ptag_t mw;
    exp_t  e;
    #1;
    for (int p = 0; p < 64; p++) bm[p] = m_busy[p];
    chk("busy", ifc.busy, bm);
    if (dec_ctrl[C_REGDST]) dst = dec_rd;
    else if (dec_ctrl[C_LINK]) dst = 5'd31;
    else dst = dec_rt;
    need = dec_ctrl[C_REGWR] && dst != 0;
    nt = -1;
    for (int p = 63; p >= 1; p--)
      if (m_free[p]) nt = p;
    acc = dec_valid && !STALL && !FLUSH
       && !ifc.issue_halt && !(need && nt < 0);
    chk("rename_stall", rename_stall, dec_valid && !acc);
    last_stall = rename_stall;
    if (acc) begin
      if (need) mw = ptag_t'(nt);
      else if (dec_ctrl[C_MEMWR]) mw = m_rat[dec_rt];
      else mw = 0;
      e.info = '0;
      e.info[5:0]    = m_rat[dec_rs];
      e.info[11:6]   = m_rat[dec_rt];
      e.info[17:12]  = mw;
      e.info[168:18] = dec_ctrl;
      e.num = m_cnt;
      e.dst = need ? dst : 5'd0;
      e.old = need ? m_rat[dst] : 6'd0;
      sb.push_back(e);
      m_cnt = (m_cnt == 32'hFFFF_FFFF) ? 32'd1 : m_cnt + 1;
      if (need) begin
        rob.push_back('{dst, ptag_t'(nt), m_rat[dst]});
        m_rat[dst] = ptag_t'(nt);
        m_free[nt] = 0;
      end
    end
    if (FLUSH) begin
      for (int p = 0; p < 64; p++) m_busy[p] = 1;
    end else begin
      if (exe_broadcast && exe_broadcast_map != 0)
        m_busy[exe_broadcast_map] = 1;
      if (acc && need) m_busy[nt] = 0;
    end
    if (rob_commit) begin
      m_rrat[rob_commit_arch] = rob_commit_new;
      if (rob_commit_old != 0) m_free[rob_commit_old] = 1;
    end
    if (FLUSH) begin
      for (int p = 0; p < 64; p++) m_free[p] = (p != 0);
      for (int i = 0; i < 32; i++) begin
        m_rat[i] = m_rrat[i];
        m_free[m_rrat[i]] = 0;
      end
      rob.delete();
    end
    @(posedge CLK);
    #2;
  endtask

  task automatic check_reset_outputs();
    chk("rst_enque", ifc.rename_enque, 0);
    chk("rst_num", ifc.rename_instr_num, 0);
    chk("rst_info", ifc.rename_issueinfo, 0);
    chk("rst_dst", rename_arch_dst, 0);
    chk("rst_old", rename_old_map, 0);
    chk("rst_busy", ifc.busy, {64{1'b1}});
  endtask

  // Monitor: a new issueinfo is presented after any non-stalled edge.
  initial begin
    logic st, rs;
    exp_t e;
    forever begin
      @(posedge CLK);
      st = STALL;
      rs = RESET;
      #1;
      if (rs && RESET && !st && ifc.rename_enque) begin
        if (sb.size() == 0) begin
          chk("unexpected_enque", 1, 0);
        end else begin
          e = sb.pop_front();
          chk("instr_num", ifc.rename_instr_num, e.num);
          chk("issueinfo", ifc.rename_issueinfo, e.info);
          chk("arch_dst", rename_arch_dst, e.dst);
          chk("old_map", rename_old_map, e.old);
        end
      end
    end
  end

  initial begin
    idle();
    m_reset();
    repeat (2) @(posedge CLK);
    #2;
    check_reset_outputs();
    RESET = 1;

    idle(); set_instr(1, 2, 3, 1, 1, 0, 0); step();
    chk("t1_mapa", ifc.rename_issueinfo[5:0], 1);
    chk("t1_mapb", ifc.rename_issueinfo[11:6], 2);
    chk("t1_mapwr", ifc.rename_issueinfo[17:12], 32);
    chk("t1_num", ifc.rename_instr_num, 1);
    chk("t1_dst", rename_arch_dst, 3);
    chk("t1_old", rename_old_map, 3);
    chk("t1_busy32", ifc.busy[32], 0);

    idle(); set_instr(3, 1, 4, 1, 1, 0, 0);
    exe_broadcast = 1; exe_broadcast_map = 32; step();
    chk("t2_mapa", ifc.rename_issueinfo[5:0], 32);
    chk("t2_mapwr", ifc.rename_issueinfo[17:12], 33);
    chk("t2_num", ifc.rename_instr_num, 2);
    chk("t2_busy32", ifc.busy[32], 1);
    chk("t2_busy33", ifc.busy[33], 0);

    idle(); set_instr(6, 5, 0, 0, 0, 1, 0); step();
    chk("sw_mapa", ifc.rename_issueinfo[5:0], 6);
    chk("sw_mapwr", ifc.rename_issueinfo[17:12], 5);
    chk("sw_dst", rename_arch_dst, 0);

    idle(); set_instr(1, 0, 0, 0, 1, 0, 0); step();
    chk("r0_mapwr", ifc.rename_issueinfo[17:12], 0);
    chk("r0_old", rename_old_map, 0);

    idle(); set_instr(1, 7, 0, 0, 1, 0, 0); step();
    chk("r7_mapwr", ifc.rename_issueinfo[17:12], 34);

    idle(); set_instr(2, 9, 0, 0, 1, 0, 0);
    ifc.issue_halt = 1; step();
    chk("halt_stall", last_stall, 1);
    chk("halt_enque", ifc.rename_enque, 0);
    ifc.issue_halt = 0; step();
    chk("halt_num", ifc.rename_instr_num, 6);
    chk("halt_mapwr", ifc.rename_issueinfo[17:12], 35);

    idle(); commit_front(); step();
    idle(); FLUSH = 1; step();
    chk("fl_enque", ifc.rename_enque, 0);
    chk("fl_busy", ifc.busy, {64{1'b1}});
    idle(); set_instr(3, 4, 8, 1, 1, 0, 0); step();
    chk("fl_mapa", ifc.rename_issueinfo[5:0], 32);
    chk("fl_mapb", ifc.rename_issueinfo[11:6], 4);
    chk("fl_mapwr", ifc.rename_issueinfo[17:12], 3);
    idle(); set_instr(1, 1, 10, 1, 1, 0, 0); step();
    chk("fl_mapwr2", ifc.rename_issueinfo[17:12], 33);

    idle(); set_instr(1, 2, 11, 1, 1, 0, 0);
    RESET = 0; #1;
    check_reset_outputs();
    m_reset();
    @(posedge CLK); #2;
    RESET = 1;

    for (int i = 0; i < 32; i++) begin
      idle(); set_instr(1, 2, ((i + 2) % 31) + 1, 1, 1, 0, 0);
      step();
    end
    idle(); set_instr(1, 2, 9, 1, 1, 0, 0); step();
    chk("ex_stall", last_stall, 1);
    chk("ex_enque", ifc.rename_enque, 0);
    commit_front();
    chk("ex_commit_old", rob_commit_old, 3);
    step();
    chk("ex_stall_commit", last_stall, 1);
    idle(); set_instr(1, 2, 9, 1, 1, 0, 0); step();
    chk("ex_go", last_stall, 0);
    chk("ex_mapwr", ifc.rename_issueinfo[17:12], 3);

    for (int i = 0; i < 1500; i++) begin
      idle();
      if (i == 700) begin
        set_instr(1, 2, 3, 1, 1, 0, 0);
        RESET = 0; #1;
        check_reset_outputs();
        m_reset();
        @(posedge CLK); #2;
        RESET = 1;
        idle();
      end
      dec_valid = ($urandom_range(9) < 8);
      dec_rs = areg_t'($urandom);
      dec_rt = areg_t'($urandom);
      dec_rd = areg_t'($urandom);
      dec_ctrl = rand_ctrl();
      STALL = ($urandom_range(9) == 0);
      FLUSH = ($urandom_range(39) == 0);
      ifc.issue_halt = ($urandom_range(9) == 0);
      exe_broadcast = ($urandom_range(2) == 0);
      exe_broadcast_map = ptag_t'($urandom);
      if ($urandom_range(2) == 0) commit_front();
      step();
    end

    idle(); step(); step();
    chk("sb_drained", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got 1 want 0");
    $fatal(1);
  end
endmodule

// File: doc/rename_dispatch.md
Name: rename_dispatch

Overview:
- Register-rename and dispatch stage; the producer end of the rename→issue interface (rename_enque, rename_instr_num, rename_issueinfo, busy).
- Maps architectural sources/destination to physical registers via a speculative RAT; allocates from a free-list bitmap; maintains the 64-entry register-ready table.
- Retirement RAT is updated by ROB commits and restores state on FLUSH.

Parameters:
- NUM_ARCH, 32, architectural registers; arch 0 is hard-wired to phys 0.
- NUM_PHYS, 64, physical registers; fixes width of busy.
- PHYS_W, 6, physical tag width.

Ports:
- CLK in 1: clock.
- RESET in 1: asynchronous reset, active-low.
- STALL in 1: global pipeline stall.
- FLUSH in 1: misprediction flush, synchronous.
- dec_valid in 1: decoded instruction present.
- dec_rs, dec_rt, dec_rd in 5 each: architectural register fields.
- dec_ctrl in 151: issueinfo bits [168:18] excluding tags: instr, pc, shamt, alu, flags, alt_pc, imm.
- rename_stall out 1: decode must hold; combinational.
- issue_halt in 1: issue queue cannot accept.
- rename_enque out 1: issueinfo valid, one cycle per instruction.
- rename_instr_num out 32: sequence number, starting at 1; 0 means none.
- rename_issueinfo out 186: [5:0] MapA, [11:6] MapB, [17:12] MapWr, [168:18] dec_ctrl verbatim, [185:169] zero.
- busy out 64: bit p = 1 means phys p holds a valid value.
- rename_arch_dst out 5: destination architectural register, to ROB.
- rename_old_map out 6: previous mapping of that register, to ROB.
- exe_broadcast in 1, exe_broadcast_map in 6: result-ready notification.
- rob_commit in 1, rob_commit_arch in 5, rob_commit_new in 6, rob_commit_old in 6: retirement.

Behaviour:
- Destination: arch_dst = RegDest ? rd : link ? 31 : rt (RegDest = dec_ctrl bit 99, link = bit 100).
- Allocation: need_alloc = RegWr (bit 93) && arch_dst != 0.
- accept = dec_valid && !STALL && !FLUSH && !issue_halt && !(need_alloc && free_empty).
- rename_stall = dec_valid && !accept.
- Source tags: MapA = RAT[rs], MapB = RAT[rt], read before this cycle's RAT write.
- MapWr when allocating: lowest-index free phys tag.
- MapWr for stores without allocation (MemWr, bit 94): RAT[rt], carrying the store-data tag.
- MapWr otherwise: 0.
- Allocation effects at the accept edge: RAT[arch_dst] ← new tag; free bit cleared; busy[new] ← 0; rename_old_map ← prior RAT[arch_dst].
- When no allocation: rename_arch_dst = 0 and rename_old_map = 0.
- Latency: all outputs are registered, 1 cycle after accept. rename_enque drops to 0 the cycle after a non-accept unless STALL is high.
- STALL holds every output register and the instruction counter.
- Instruction counter increments by 1 per accept. It is not reset by FLUSH and wraps 2^32−1 → 1, skipping 0.
- Broadcast: busy[exe_broadcast_map] ← 1 at the edge; tag 0 is ignored.
- Broadcast and commit apply regardless of STALL.
- If allocation and broadcast hit the same tag in one cycle, the allocation (busy ← 0) wins.
- Commit: RRAT[rob_commit_arch] ← rob_commit_new; free[rob_commit_old] ← 1 unless the tag is 0.
- A tag freed by commit cannot be allocated until the next cycle.
- FLUSH, with priority over dispatch:
  - RAT ← RRAT, including a same-cycle commit.
  - free[p] = 1 iff p ≠ 0 and p is not in the RRAT.
  - busy ← all 1.
  - rename_enque, issueinfo, arch_dst and old_map ← 0 next cycle.
- Reset (async):
  - RAT = RRAT = identity (arch i → phys i).
  - free = phys 32..63.
  - busy = all 1.
  - Counter = 1.
  - All outputs 0, except busy = all 1.
- Invariant: phys 0 is never allocated and busy[0] always reads 1.

Decomposition:
- Shared package: NUM_ARCH, NUM_PHYS, PHYS_W, and the issueinfo field bit offsets. The issue queue slices issueinfo using the same package constants.
- Sub-module rename_freelist: 64-bit free bitmap with lowest-index priority-encoder allocate, free port, empty flag, and flush reload from an RRAT-derived mask.

Test Plan:
- Allocate after reset: add r3,r1,r2 (RegDest, rd=3) → next cycle enque=1, MapA=1, MapB=2, MapWr=32, instr_num=1, arch_dst=3, old_map=3, busy[32]=0.
- Dependent instruction plus broadcast: then add r4,r3,r1 → MapA=32, MapWr=33, instr_num=2; broadcast map=32 → busy[32]=1 the next cycle.
- Store and r0 write: sw r5,0(r6) → MapA=6, MapWr=5, no allocation, free count unchanged; addi r0 → MapWr=0, old_map=0.
- Free-list exhaustion: 32 allocating instructions with no commits, 33rd held with rename_stall=1 and enque=0. Commit old=3 → stall clears the following cycle and the 33rd gets MapWr=3.
- Flush restore: after renaming r3→32 and r4→33 with only r3 committed, assert FLUSH → RAT[3]=32, RAT[4]=4, free includes 33 and excludes 32, busy all 1, enque=0.
- Back-pressure and mid-operation reset: issue_halt=1 with dec_valid → rename_stall=1 and the counter is unchanged. RESET low mid-stream → all outputs and tables at reset values immediately.
